mpmc10_chan_arb: RTL
====================

MPMC10_CHAN_ARB -- requirements
Module: mpmc10_chan_arb

Interface
REQ-001 SHALL have parameter NCH, default 8, number of requesting channels (fixed 8 in this release).
REQ-002 SHALL have parameter HIPRI, default 8'h01, mask of channels served ahead of all others.
REQ-003 SHALL have parameter TMO, default 20'd1000000, watchdog limit in cycles for one transaction.
REQ-004 SHALL have parameter LMAX, default 4, max back-to-back locked grants to one channel.
REQ-005 SHALL have clk  input  1  single clock; all state changes on posedge clk.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have req  input  8  per-channel transaction request, level.
REQ-008 SHALL have lock  input  8  per-channel lock (LWAR/SWCR pairing), sampled with done.
REQ-009 SHALL have mem_rdy  input  1  memory state machine in IDLE and able to accept a transaction.
REQ-010 SHALL have done  input  1  one-cycle pulse, memory state machine finished current transaction.
REQ-011 SHALL have gnt  output  8  one-hot grant, zero when no grant.
REQ-012 SHALL have gnt_ch  output  4  encoded granted channel, 4'hF when none.
REQ-013 SHALL have start  output  1  one-cycle strobe launching the transaction for gnt_ch.
REQ-014 SHALL have tmo  output  1  one-cycle pulse, watchdog expiry.
REQ-015 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, GRANT, WAIT, RECOVER, all registered.
REQ-017 IDLE: when mem_rdy=1 and |req, SHALL pick winner, load gnt/gnt_ch, go GRANT next cycle; else stay IDLE.
REQ-018 Winner: if |(req & HIPRI), round-robin among req & HIPRI; else round-robin among req.
REQ-019 Round-robin search SHALL start at last+1 and wrap modulo 8; last SHALL update to winner on entry to GRANT.
REQ-020 GRANT: start=1 for exactly that cycle; SHALL go WAIT next cycle unconditionally.
REQ-021 WAIT: watchdog counter (20 bits) increments each cycle from 0; done ignored in any state except WAIT.
REQ-022 WAIT, done=1, lock[gnt_ch]=1, lock_cnt<LMAX-1: SHALL go GRANT, same channel, no re-arbitration, lock_cnt+1.
REQ-023 WAIT, done=1, otherwise: SHALL go RECOVER, lock_cnt cleared.
REQ-024 WAIT, counter==TMO-1 and done=0: tmo=1 for that cycle's following cycle, go RECOVER, lock_cnt cleared.
REQ-025 done and watchdog terminal in same cycle: done SHALL win, no tmo.
REQ-026 RECOVER: gnt SHALL be 0 and gnt_ch 4'hF; SHALL go IDLE next cycle (one-cycle turnaround).
REQ-027 gnt/gnt_ch SHALL be held stable through GRANT and WAIT regardless of req changes; dropping req does not abort.
REQ-028 Watchdog counter SHALL reset to 0 on every entry to GRANT.
REQ-029 Latency: req with mem_rdy in IDLE at cycle N -> start at N+1; done at M -> next earliest start M+3.
REQ-030 gnt SHALL never have more than one bit set; gnt_ch SHALL always equal the encoding of gnt or 4'hF.

Reset
REQ-031 On rst=0, asynchronously: state IDLE, gnt 0, gnt_ch 4'hF, start 0, tmo 0, busy 0, last 7, counter 0, lock_cnt 0.
REQ-032 rst asserted mid-transaction SHALL abandon it with no start/tmo pulse on release; first grant after release favours ch0.

Verification
REQ-033 req=8'h06, HIPRI=0, mem_rdy=1 after reset -> start with gnt_ch=1; after done, next grant gnt_ch=2.
REQ-034 req=8'h81 held, HIPRI=8'h01 -> every grant is ch0; ch7 never granted while req[0]=1.
REQ-035 ch3 granted, lock=8'h08 held, done each WAIT -> exactly 4 consecutive starts for ch3, then RECOVER, busy low one cycle.
REQ-036 TMO=16, grant ch5, no done -> tmo pulse once, gnt=0 next, IDLE two cycles after expiry.
REQ-037 req=8'hFF, mem_rdy=0 -> no start; mem_rdy rises -> start next cycle with gnt_ch=0.
REQ-038 rst low during WAIT of ch4 -> gnt=0, gnt_ch=4'hF immediately; after release with req=8'h11, gnt_ch=0 first.

Source files
------------

// File: rtl/mpmc10_chan_arb.sv
// Channel arbiter in front of the MPMC10 memory state machine: a high-priority
// class plus round-robin, locked back-to-back grants, and a per-transaction watchdog.
module mpmc10_chan_arb #(
  parameter int               NCH   = 8,
  parameter logic [NCH-1:0]   HIPRI = 8'h01,
  parameter logic [19:0]      TMO   = 20'd1000000,
  parameter int               LMAX  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] lock,
  input  logic           mem_rdy,
  input  logic           done,
  output logic [NCH-1:0] gnt,
  output logic [3:0]     gnt_ch,
  output logic           start,
  output logic           tmo,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t         state;
  logic [2:0]     last;
  logic [19:0]    wdog;
  logic [7:0]     lock_cnt;
  logic [NCH-1:0] hi_req;
  logic [NCH-1:0] cand;
  logic [2:0]     win;

  // Search starts just after the previous winner so every requester gets a turn.
  function automatic logic [2:0] rr_pick(input logic [NCH-1:0] mask, input logic [2:0] prev);
    logic [2:0] idx;
    logic       found;
    rr_pick = prev;
    found   = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = prev + 3'(i);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    hi_req = req & HIPRI;
    cand   = (|hi_req) ? hi_req : req;
    win    = rr_pick(cand, last);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_ch   <= 4'hF;
      start    <= 1'b0;
      tmo      <= 1'b0;
      busy     <= 1'b0;
      last     <= 3'd7;
      wdog     <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          start <= 1'b0;
          tmo   <= 1'b0;
          if (mem_rdy && |req) begin
            state    <= GRANT;
            gnt      <= '0;
            gnt[win] <= 1'b1;
            gnt_ch   <= {1'b0, win};
            last     <= win;
            wdog     <= '0;
            lock_cnt <= '0;
            start    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          start <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // done takes precedence over a watchdog expiry in the same cycle
          if (done) begin
            if (lock[gnt_ch[2:0]] && lock_cnt < 8'(LMAX - 1)) begin
              state    <= GRANT;
              start    <= 1'b1;
              wdog     <= '0;
              lock_cnt <= lock_cnt + 8'd1;
            end else begin
              state    <= RECOVER;
              gnt      <= '0;
              gnt_ch   <= 4'hF;
              lock_cnt <= '0;
            end
          end else if (wdog == TMO - 20'd1) begin
            state    <= RECOVER;
            tmo      <= 1'b1;
            gnt      <= '0;
            gnt_ch   <= 4'hF;
            lock_cnt <= '0;
          end else begin
            wdog <= wdog + 20'd1;
          end
        end
        RECOVER: begin
          tmo   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
